// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// out_ovf exists only when ADD_SEQ_OVERFLOW_EN is defined.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_sub;
    logic                  in_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
`ifdef ADD_SEQ_OVERFLOW_EN
    logic                  out_ovf;
`endif
    logic                  busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout,
`ifdef ADD_SEQ_OVERFLOW_EN
        input  out_ovf,
`endif
        input  busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout,
`ifdef ADD_SEQ_OVERFLOW_EN
        output out_ovf,
`endif
        output busy
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract built from one 16-bit slice stepped LSW first.
// Define ADD_SEQ_OVERFLOW_EN to add the registered signed-overflow output out_ovf.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state;
    logic [IDXW-1:0]       idx;
    logic [WORDS-1:0][15:0] aQ;
    logic [WORDS-1:0][15:0] bQ;
    logic [WORDS-1:0][15:0] sumQ;
    logic                  carryQ;
    logic                  coutQ;
    logic                  readyQ;
    logic                  validQ;
    logic                  busyQ;
    logic [16:0]           slice;

    // bQ already holds ~B for subtract, so the slice is always a plain add.
    always_comb begin
        slice = {1'b0, aQ[idx]} + {1'b0, bQ[idx]} + {16'b0, carryQ};
    end

`ifdef ADD_SEQ_OVERFLOW_EN
    logic ovfQ;
    logic msbCarry;

    always_comb begin
        msbCarry = aQ[idx][15] ^ bQ[idx][15] ^ slice[15];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            aQ     <= '0;
            bQ     <= '0;
            sumQ   <= '0;
            carryQ <= 1'b0;
            coutQ  <= 1'b0;
            readyQ <= 1'b1;
            validQ <= 1'b0;
            busyQ  <= 1'b0;
`ifdef ADD_SEQ_OVERFLOW_EN
            ovfQ   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        aQ     <= bus.in_a;
                        bQ     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carryQ <= bus.in_sub | bus.in_cin;
                        idx    <= '0;
                        readyQ <= 1'b0;
                        busyQ  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sumQ[idx] <= slice[15:0];
                    carryQ    <= slice[16];
                    if (idx == LAST) begin
                        coutQ  <= slice[16];
`ifdef ADD_SEQ_OVERFLOW_EN
                        ovfQ   <= msbCarry ^ slice[16];
`endif
                        validQ <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        validQ <= 1'b0;
                        busyQ  <= 1'b0;
                        readyQ <= 1'b1;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is forced low while reset is asserted, then rises the cycle after.
    assign bus.in_ready  = readyQ & ~rst;
    assign bus.out_valid = validQ;
    assign bus.out_sum   = sumQ;
    assign bus.out_cout  = coutQ;
    assign bus.busy      = busyQ;
`ifdef ADD_SEQ_OVERFLOW_EN
    assign bus.out_ovf   = ovfQ;
`endif
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: directed cases then random traffic
// against a full-width arithmetic reference model.
module tb_wide_add_sequencer;
    localparam int WORDS = 4;
    localparam int W = 16 * WORDS;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wide_add_sequencer_if #(.WORDS(WORDS)) ifc ();

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t expQ[$];

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference: plain wide arithmetic with sign-rule overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t       r;
        logic [W:0] full;
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.sum  = full[W-1:0];
            r.cout = full[W];
            r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return r;
    endfunction

    // Monitor: every completed output transfer is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (expQ.size() == 0) begin
                timeoutFail("unexpected_out_valid");
            end else begin
                e = expQ.pop_front();
                checkOutput("out_sum", ifc.out_sum, e.sum);
                checkOutput("out_cout", W'(ifc.out_cout), W'(e.cout));
`ifdef ADD_SEQ_OVERFLOW_EN
                checkOutput("out_ovf", W'(ifc.out_ovf), W'(e.ovf));
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
        int lat;
        bit ok;
        expQ.push_back(model(a, b, sub, cin));
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_sub   = sub;
        ifc.in_cin   = cin;
        ifc.in_valid = 1'b1;
        waitAccept(ok);
        if (!ok) begin
            timeoutFail("accept");
            ifc.in_valid = 1'b0;
            return;
        end
        tick;
        // Scramble inputs after acceptance; the latched operands must win.
        ifc.in_valid = 1'b0;
        ifc.in_a     = {$urandom, $urandom};
        ifc.in_b     = {$urandom, $urandom};
        ifc.in_sub   = ~sub;
        ifc.in_cin   = ~cin;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (ifc.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail("out_valid");
        else checkOutput("latency", W'(lat), W'(WORDS + 1));
        tick;
    endtask

    initial begin
        exp_t e;
        bit   ok;
        int   t1, t2;

        rst = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_sub    = 1'b0;
        ifc.in_cin    = 1'b0;
        ifc.out_ready = 1'b1;
        tick;
        tick;
        @(negedge clk);
        checkOutput("rst_in_ready", W'(ifc.in_ready), W'(0));
        tick;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", W'(ifc.in_ready), W'(1));
        checkOutput("post_rst_out_valid", W'(ifc.out_valid), W'(0));
        checkOutput("post_rst_out_sum", ifc.out_sum, W'(0));
        checkOutput("post_rst_out_cout", W'(ifc.out_cout), W'(0));
        checkOutput("post_rst_busy", W'(ifc.busy), W'(0));
        tick;

        $display("[TB] carry ripple and subtract");
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        applyStimulus(64'd5, 64'd7, 1'b1, 1'b1);
        applyStimulus(64'd7, 64'd5, 1'b1, 1'b0);

        $display("[TB] output backpressure");
        ifc.out_ready = 1'b0;
        e = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_0000_1111_2222, 1'b0, 1'b1);
        applyStimulus(64'h0123_4567_89AB_CDEF, 64'hFEDC_0000_1111_2222, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_sum", ifc.out_sum, e.sum);
            checkOutput("bp_out_valid", W'(ifc.out_valid), W'(1));
            checkOutput("bp_in_ready", W'(ifc.in_ready), W'(0));
            checkOutput("bp_busy", W'(ifc.busy), W'(1));
            tick;
        end
        ifc.out_ready = 1'b1;
        tick;
        @(negedge clk);
        checkOutput("bp_release_in_ready", W'(ifc.in_ready), W'(1));
        tick;

        $display("[TB] back-to-back requests");
        expQ.push_back(model(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0));
        ifc.in_a     = 64'h1111_2222_3333_4444;
        ifc.in_b     = 64'h0F0F_0F0F_0F0F_0F0F;
        ifc.in_sub   = 1'b0;
        ifc.in_cin   = 1'b0;
        ifc.in_valid = 1'b1;
        waitAccept(ok);
        t1 = cyc;
        tick;
        expQ.push_back(model(64'h8000_0000_0000_0000, 64'h0000_0000_0001_0000, 1'b1, 1'b0));
        ifc.in_a   = 64'h8000_0000_0000_0000;
        ifc.in_b   = 64'h0000_0000_0001_0000;
        ifc.in_sub = 1'b1;
        waitAccept(ok);
        t2 = cyc;
        if (!ok) timeoutFail("b2b_accept");
        else checkOutput("b2b_interval", W'(t2 - t1), W'(WORDS + 2));
        tick;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 60 && expQ.size() != 0; i++) tick;

        $display("[TB] reset mid-operation");
        ifc.in_a     = 64'hAAAA_BBBB_CCCC_DDDD;
        ifc.in_b     = 64'h1;
        ifc.in_sub   = 1'b0;
        ifc.in_valid = 1'b1;
        waitAccept(ok);
        tick;
        ifc.in_valid = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready_low", W'(ifc.in_ready), W'(0));
        tick;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", W'(ifc.in_ready), W'(1));
        checkOutput("midrst_out_valid", W'(ifc.out_valid), W'(0));
        checkOutput("midrst_out_sum", ifc.out_sum, W'(0));
        checkOutput("midrst_out_cout", W'(ifc.out_cout), W'(0));
        checkOutput("midrst_busy", W'(ifc.busy), W'(0));
        tick;
        applyStimulus(64'h1234, 64'h1, 1'b0, 1'b0);

        $display("[TB] overflow boundaries");
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
        applyStimulus(64'd3, 64'd4, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!ifc.out_ready) begin
                repeat ($urandom_range(0, 5)) tick;
                ifc.out_ready = 1'b1;
                tick;
                tick;
            end
        end

        for (int i = 0; i < 60 && expQ.size() != 0; i++) tick;
        checkOutput("queue_drained", W'(expQ.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
